// File: rtl/arb_pkg.sv
// Shared types and helpers for the CPU/DMA data-port arbiter.
package arb_pkg;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hC000_0000;

  // The MMIO window is the quarter of the address space selected by the two top address bits.
  function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:30] == base[31:30];
  endfunction

endpackage

// File: rtl/arb_burst_limiter.sv
// Counts consecutive contended DMA grants under dma_lock and reports whether DMA may keep the port.
module arb_burst_limiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic cpu_gnt,
  input  logic dma_gnt,
  input  logic dma_lock,
  output logic burst_ok
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  logic [CW-1:0] cnt_q, cnt_d;

  // Only grants that actually starve a waiting CPU count toward the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_lock || cpu_gnt) begin
      cnt_d = '0;
    end else if (dma_gnt && cpu_req && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign burst_ok = (cnt_q < MAX_C);

endmodule

// File: rtl/data_port_arbiter.sv
// Shares the unified memory data port between the CPU and a DMA/loader master,
// with alternating priority, bounded DMA lock bursts and an MMIO guard for DMA.
module data_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  owner_t      last_gnt_q, last_gnt_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic        dma_err_q, dma_err_d;
  logic        cpu_win, dma_win;
  logic        burst_ok;
  logic        dma_reject;

  arb_burst_limiter #(.MAX_BURST(MAX_BURST)) u_burst (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_req  (cpu_req),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt),
    .dma_lock (dma_lock),
    .burst_ok (burst_ok)
  );

  // On a tie DMA keeps the port only while its lock burst has budget left.
  always_comb begin
    cpu_win = cpu_req;
    dma_win = dma_req;
    if (cpu_req && dma_req) begin
      dma_win = (last_gnt_q == OWN_CPU) || (dma_lock && burst_ok);
      cpu_win = !dma_win;
    end
  end

  assign cpu_gnt    = cpu_win && reset_n;
  assign dma_gnt    = dma_win && reset_n;
  assign dma_reject = dma_gnt && is_mmio(dma_addr, MMIO_BASE);

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_a  = cpu_addr;
      mem_wd = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we = dma_we && !dma_reject;
      mem_a  = dma_addr;
      mem_wd = dma_wdata;
    end
  end

  always_comb begin
    last_gnt_d   = last_gnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dma_rvalid_d = dma_gnt && !dma_we && !dma_reject;
    dma_err_d    = dma_reject;
    if (cpu_gnt) last_gnt_d = OWN_CPU;
    if (dma_gnt) last_gnt_d = OWN_DMA;
    if (cpu_rvalid_d) cpu_rdata_d = mem_rd;
    if (dma_rvalid_d) dma_rdata_d = mem_rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q   <= OWN_DMA;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_err_q    <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_err    = dma_err_q;

endmodule
